// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet pipeline constants and window FSM state type
package lenet_pkg;

    localparam int PIX_WIDTH   = 8;
    localparam int IMG_W       = 32;
    localparam int IMG_H       = 32;
    localparam int KERNEL_SIZE = 5;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } win_state_t;

endpackage

// File: rtl/row_buffer.sv
// rtl/row_buffer.sv - enable-gated line delay of one image row
module row_buffer
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_WIDTH,
    parameter int DEPTH      = IMG_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  primed
);

    localparam int FW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] line [DEPTH];
    logic [FW-1:0]         fill;

    // Shift only on accepted pixels so input gaps freeze the line.
    always_ff @(posedge clk) begin
        if (en) begin
            line[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    // Count shifts since reset until the line holds a full row of real data.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill <= '0;
        end else if (en && (fill != FW'(DEPTH))) begin
            fill <= fill + 1'b1;
        end
    end

    assign dout   = line[DEPTH-1];
    assign primed = (fill == FW'(DEPTH));

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming KxK sliding-window generator for conv1
module conv_window_gen
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_WIDTH,
    parameter int IMG_WIDTH  = IMG_W,
    parameter int IMG_HEIGHT = IMG_H,
    parameter int K          = KERNEL_SIZE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     Data_In,
    input  logic                      Data_In_Valid,
    output logic [K*K*DATA_WIDTH-1:0] Window_Out,
    output logic                      Window_Valid,
    output logic                      Frame_Done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(K - 2);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    win_state_t            state, state_nxt;
    logic                  emit;
    logic                  last_pix;

    logic [DATA_WIDTH-1:0] rb_in  [K-1];
    logic [DATA_WIDTH-1:0] rb_out [K-1];
    logic [K-2:0]          primed;

    logic [DATA_WIDTH-1:0] win     [K][K];
    logic [DATA_WIDTH-1:0] win_nxt [K][K];
    logic [K*K*DATA_WIDTH-1:0] win_flat;

    // Cascade: buffer 0 sees the live pixel, buffer i sees buffer i-1's output.
    always_comb begin
        rb_in[0] = Data_In;
        for (int i = 1; i < K-1; i++) begin
            rb_in[i] = rb_out[i-1];
        end
    end

    for (genvar gi = 0; gi < K-1; gi++) begin : g_rb
        row_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH)
        ) u_row_buffer (
            .clk    (clk),
            .reset  (reset),
            .en     (Data_In_Valid),
            .din    (rb_in[gi]),
            .dout   (rb_out[gi]),
            .primed (primed[gi])
        );
    end

    // Next window: shift every row left and append the new column, oldest row on top.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
        end
        for (int r = 0; r < K-1; r++) begin
            win_nxt[r][K-1] = rb_out[K-2-r];
        end
        win_nxt[K-1][K-1] = Data_In;
    end

    // Window register advances only on accepted pixels; validity comes from the counters.
    always_ff @(posedge clk) begin
        if (Data_In_Valid) begin
            win <= win_nxt;
        end
    end

    // Flatten the next window so the emitted value matches the pixel being accepted.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_nxt[r][c];
            end
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (Data_In_Valid) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and window-emit decision.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        last_pix  = (row == ROW_LAST) && (col == COL_LAST);
        case (state)
            S_FILL: begin
                if (Data_In_Valid && (row == ROW_FILL_LAST) && (col == COL_LAST)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (Data_In_Valid && (col >= COL_FIRST_WIN) && (&primed)) begin
                    emit = 1'b1;
                end
                if (Data_In_Valid && last_pix) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // Registered outputs; Window_Out holds between windows.
    always_ff @(posedge clk) begin
        if (reset) begin
            Window_Out   <= '0;
            Window_Valid <= 1'b0;
            Frame_Done   <= 1'b0;
        end else begin
            Window_Valid <= emit;
            Frame_Done   <= emit && last_pix;
            if (emit) begin
                Window_Out <= win_flat;
            end
        end
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming sliding-window generator placed directly upstream of the conv1 MAC array and its Delay-based control alignment.
- Accepts raster-order pixels with a valid strobe and emits one flattened KxK window per valid output position.
- Produces Window_Valid and Frame_Done, which the downstream Delay instance pipelines to line up with the MAC/adder-tree latency.
- No backpressure: the consumer must accept every window.

Parameters:
- DATA_WIDTH, 8, bits per pixel
- IMG_WIDTH, 32, pixels per row
- IMG_HEIGHT, 32, rows per frame
- K, 5, kernel size (window is KxK)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Data_In  input  DATA_WIDTH  pixel, raster order (row-major, left to right)
- Data_In_Valid  input  1  Data_In accepted this cycle when high
- Window_Out  output  K*K*DATA_WIDTH  flattened window; element (r,c) at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is oldest row, c=0 is leftmost column
- Window_Valid  output  1  Window_Out valid this cycle (single-cycle pulse per window)
- Frame_Done  output  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. While reset is high at a clk edge:
  - col/row counters go to 0 and the FSM goes to S_FILL.
  - Window_Out, Window_Valid and Frame_Done go to 0.
  - Line-buffer contents need not be cleared, because output validity is gated by the counters.
- Storage:
  - K-1 row buffers, each IMG_WIDTH deep, shift only when Data_In_Valid=1.
  - A KxK shift-register window; each accepted pixel shifts every window row left by one.
  - The new rightmost column is {row_buf[K-2] out, ..., row_buf[0] out, Data_In}, oldest row first.
- Counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1.
  - Both advance only on an accepted pixel.
  - col wraps to 0 and increments row. At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0; this is the frame end.
- FSM:
  - S_FILL: active while row < K-1. No windows are emitted. Moves to S_RUN on acceptance of pixel (K-2, IMG_WIDTH-1).
  - S_RUN: a window is emitted for each accepted pixel with col >= K-1. Returns to S_FILL on acceptance of the last pixel of the frame.
- Latency: Window_Valid asserts exactly 1 cycle after the clk edge that accepts the pixel completing the window (registered output).
- Outputs outside valid cycles:
  - Window_Out holds its last value when Window_Valid=0.
  - Window_Valid=0 on any cycle without a qualifying accepted pixel.
- Window count: exactly (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1) windows per frame; 784 at defaults.
- Column boundary: no window is emitted for col < K-1, including the first K-1 pixels of every row. Windows never straddle rows.
- Input gaps: Data_In_Valid=0 freezes all counters, buffers and window state. Arbitrary gaps change neither output values nor the window count.
- Frame_Done: asserts together with Window_Valid for the window completed by pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Back-to-back frames: the next frame's pixel (0,0) may arrive the cycle after the frame's last pixel, and is processed with no lost pixels.
- Reset mid-frame: the partial frame is discarded. The first pixel accepted after reset deasserts is treated as (0,0).
- Reset/valid collision: reset has priority over Data_In_Valid in the same cycle.
- Data handling: pure data movement; no arithmetic on pixel values. Counter widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT).

Decomposition:
- Shared package lenet_pkg:
  - PIX_WIDTH, IMG_W/IMG_H per layer, KERNEL_SIZE.
  - FSM state typedef (S_FILL, S_RUN).
- One sub-module, row_buffer:
  - Enable-gated shift line of depth IMG_WIDTH, width DATA_WIDTH, with synchronous reset on its valid-tracking only.
  - Instantiated K-1 times.
  - Must not be replaced by a free-running delay line, since input gaps must freeze it.

Test Plan:
- First window: DATA_WIDTH=16, continuous valid, pixel value = row*32+col. First Window_Valid appears 1 cycle after accepting pixel 132 (row 4, col 4), with element(0,0)=0, element(0,4)=4, element(4,0)=128, element(4,4)=132.
- Full frame: 1024 continuous pixels give exactly 784 Window_Valid pulses and one Frame_Done. Frame_Done coincides with the window whose element(4,4)=1023 and element(0,0)=891.
- Random gaps: random Data_In_Valid (~50% duty). Window sequence and values are identical to the continuous run, and there are no Window_Valid pulses on cycles following a non-accepted cycle.
- Mid-frame reset: reset for 1 cycle after 500 pixels, then a fresh full frame. Outputs are 0 during reset, the first window again has element(0,0)=0, and 784 windows and one Frame_Done follow.
- Back-to-back frames: two frames with no idle cycle between them. The second frame's first window appears 1 cycle after its pixel 132 and equals the first-frame values; the total is 1568 windows and 2 Frame_Done pulses.
- Row boundary: pixels (5,0)..(5,3) produce no Window_Valid. Pixel (5,4) produces a window with element(0,0)=32 and element(4,4)=164.
